// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle of the bit-serial adder; slave side is the adder itself.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int unsigned N = DefaultWidth
);

  logic         start;
  logic         abort;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  modport master (
    output start, abort, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, abort, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/FA.sv
// Gate-level single-bit full adder cell.
module FA (
  input  wire a_i,
  input  wire b_i,
  input  wire ci_i,
  output wire s_o,
  output wire co_o
);

  wire ab_x;
  wire ab_a;
  wire c_a;

  xor g_x0 (ab_x, a_i, b_i);
  xor g_x1 (s_o, ab_x, ci_i);
  and g_a0 (ab_a, a_i, b_i);
  and g_a1 (c_a, ab_x, ci_i);
  or  g_o0 (co_o, ab_a, c_a);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per RUN cycle.
// Result and carry-out are registered and held between completions.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned N = DefaultWidth
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(N);

  state_e          state_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    work_q;
  logic [N-1:0]    sum_q;
  logic            carry_q;
  logic            cout_q;
  logic            busy_q;
  logic            done_q;
  logic [CntW-1:0] cnt_q;

  logic fa_s;
  logic fa_co;

  FA u_fa (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // abort is meaningless here, so start wins when both are high
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            work_q  <= {fa_s, work_q[N-1:1]};
            carry_q <= fa_co;
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CntW'(N - 1)) begin
              sum_q   <= {fa_s, work_q[N-1:1]};
              cout_q  <= fa_co;
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of the bit-serial adder controller.
module tb_serial_add_ctrl;

  localparam int unsigned N = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  initial forever #5 clk = ~clk;

  serial_add_ctrl_if #(.N(N)) bus ();

  serial_add_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Caller is just after a clock edge. Holds start until accepted, then
  // scrambles the operand inputs and waits for done.
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic c,
                    output int acc_edges, output int acc_cyc,
                    output logic [7:0] s, output logic co);
    int n;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    bus.start = 1'b1;
    acc_edges = 0;
    do begin
      @(posedge clk); #1;
      acc_edges++;
    end while (!bus.busy && acc_edges < 10);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.cin   = ~c;
    acc_cyc   = cyc;
    chk("accept_busy", 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, N);
    s  = bus.sum;
    co = bus.cout;
  endtask

  initial begin
    int         acc_edges;
    int         acc_cyc;
    int         prev_cyc;
    int         dcount;
    logic [7:0] s;
    logic       co;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] ref_v;

    vecs[0]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[7]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[8]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[9]  = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[10] = '{8'hFE, 8'h01, 1'b1, 8'h00, 1'b1};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    rst_n     = 1'b0;
    #3;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven directed vectors, each started from IDLE
    for (int i = 0; i < 11; i++) begin
      op(vecs[i].a, vecs[i].b, vecs[i].cin, acc_edges, acc_cyc, s, co);
      chk("vec_accept_edges", acc_edges, 1);
      chk($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].cout));
      @(posedge clk); #1;
      chk("vec_done_one_cycle", 32'(bus.done), 32'd0);
      chk("vec_idle_busy", 32'(bus.busy), 32'd0);
    end

    // start pulsed mid-RUN and in DONE is ignored
    bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ign_accept", 32'(bus.busy), 32'd1);
    dcount = 0;
    for (int i = 1; i <= int'(N) + 4; i++) begin
      bus.start = (i == 3) || (i == int'(N) + 1);
      if (i == 3) begin
        bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) dcount++;
    end
    chk("ign_done_count", dcount, 1);
    chk("ign_busy", 32'(bus.busy), 32'd0);
    chk("ign_sum", 32'(bus.sum), 32'h46);
    chk("ign_cout", 32'(bus.cout), 32'd0);

    // Abort mid-RUN keeps the previous result
    op(8'h0F, 8'h01, 1'b0, acc_edges, acc_cyc, s, co);
    chk("abt_prev_sum", 32'(s), 32'h10);
    @(posedge clk); #1;
    bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abt_busy", 32'(bus.busy), 32'd0);
    chk("abt_done", 32'(bus.done), 32'd0);
    dcount = 0;
    for (int i = 0; i < int'(N) + 2; i++) begin
      @(posedge clk); #1;
      if (bus.done) dcount++;
    end
    chk("abt_no_done", dcount, 0);
    chk("abt_sum_held", 32'(bus.sum), 32'h10);
    chk("abt_cout_held", 32'(bus.cout), 32'd0);
    // abort together with start in IDLE: start wins
    bus.abort = 1'b1;
    op(8'h03, 8'h04, 1'b0, acc_edges, acc_cyc, s, co);
    chk("abt_start_edges", acc_edges, 1);
    chk("abt_start_sum", 32'(s), 32'h07);
    @(posedge clk); #1;

    // Asynchronous reset mid-RUN
    bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_sum", 32'(bus.sum), 32'd0);
    chk("arst_cout", 32'(bus.cout), 32'd0);
    #1 rst_n = 1'b1;
    op(8'h21, 8'h10, 1'b1, acc_edges, acc_cyc, s, co);
    chk("arst_accept_edges", acc_edges, 1);
    chk("arst_sum_after", 32'(s), 32'h32);
    chk("arst_cout_after", 32'(co), 32'd0);
    @(posedge clk); #1;

    // Random back-to-back operations with a reference adder
    prev_cyc = 0;
    for (int j = 0; j < 1000; j++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      ref_v = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      op(ra, rb, rc, acc_edges, acc_cyc, s, co);
      chk("rnd_sum", 32'(s), 32'(ref_v[7:0]));
      chk("rnd_cout", 32'(co), 32'(ref_v[8]));
      if (j > 0) chk("rnd_interval", acc_cyc - prev_cyc, int'(N) + 2);
      prev_cyc = acc_cyc;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: N, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of an in-progress addition.
REQ-006 a  input  N  addend A; captured on the accepted start.
REQ-007 b  input  N  addend B; captured on the accepted start.
REQ-008 cin  input  1  carry-in; captured on the accepted start.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 sum  output  N  registered result; held between completions.
REQ-012 cout  output  1  registered carry-out; held between completions.

Function
REQ-013 The block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, using exactly one single-bit full-adder instance, one bit per RUN cycle.
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE with start=1 at an edge SHALL load the A/B shift registers from a/b, load the carry register from cin, clear the bit counter, and go to RUN.
REQ-016 Each RUN edge SHALL do the following:
- present shift-register bit 0 of A, bit 0 of B and the carry register to the full adder;
- shift the adder sum output into the working-sum register at the MSB;
- load the carry register with the adder carry-out;
- shift A and B right;
- increment the counter.
REQ-017 The RUN edge at which the counter equals N-1 SHALL transfer the working sum to sum, the adder carry-out to cout, and go to DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-019 Latency: start accepted at edge k gives done=1 in the cycle after edge k+N; back-to-back operations SHALL have a throughput of one result per N+2 cycles.
REQ-020 start SHALL be ignored while busy=1, including in DONE; no queueing.
REQ-021 abort=1 in RUN SHALL return to IDLE at that edge with no done pulse and sum/cout unchanged; abort in IDLE or DONE SHALL have no effect.
REQ-022 If abort and start are both 1 in IDLE, start SHALL be accepted.
REQ-023 sum/cout SHALL change only at the completing RUN edge or at reset; a/b/cin changes after acceptance SHALL not affect the result.
REQ-024 Carry from bit N-1 SHALL appear on cout and SHALL not wrap into bit 0.

Reset
REQ-025 rst_n=0 SHALL immediately, regardless of clk, force state=IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, shift registers and carry register.
REQ-026 Reset asserted mid-RUN SHALL discard the operation; the block SHALL accept start on the first edge after rst_n deasserts.

Structure
REQ-027 Shared package serial_add_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the default-width constant; the counter width SHALL be $clog2(N).
REQ-028 The datapath bit cell SHALL be the team's existing gate-level full-adder cell FA, instantiated once; no other sub-module.

Verification
REQ-029 N=8, a=0x0F, b=0x01, cin=0 -> done in the cycle after the 8th edge following start; sum=0x10, cout=0.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-031 start pulsed at RUN cycle 3 and again during DONE -> ignored; exactly one done; result matches the first operands.
REQ-032 Previous result 0x10; abort at RUN cycle 4 -> busy drops next cycle, no done, sum stays 0x10; a new start then completes normally.
REQ-033 rst_n low asynchronously mid-RUN -> busy=0, sum=0, cout=0 without a clock edge; start on the first edge after release -> correct result.
REQ-034 Random a/b/cin, 1000 back-to-back operations -> each result equals the reference sum; the start-to-start interval is N+2 cycles.
